inst_mem_resp: RTL
==================

Name: inst_mem_resp

Overview:
Instruction-memory responder for core_single. It accepts fetch requests (pc) from the core and returns 32-bit instruction words after a fixed pipeline latency, with valid/ready flow control and a fault flag. Instruction storage is a word array filled through a loader write port, used by benches and by boot logic. It sits between core_single's fetch side and the program image and replaces hand-driven inst stimulus.

Parameters:
DEPTH_LOG2, 8, log2 of storage depth in 32-bit words (256 words = 1 KiB).
LATENCY, 1, request-to-response cycles; legal range 1..4.
NOP_INST, 32'h0000_0013, word returned on fault and held at reset (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
pc  in  32  fetch byte address from the core.
req_valid  in  1  fetch request present.
req_ready  out  1  responder can accept a request this cycle.
inst  out  32  returned instruction word.
inst_valid  out  1  inst and fault are valid.
inst_ready  in  1  core consumes the response.
fault  out  1  response is for a misaligned or out-of-range pc.
ld_en  in  1  loader write enable.
ld_addr  in  DEPTH_LOG2  loader word index.
ld_data  in  32  loader write data.

Behaviour:
- Reset (async, active-high): all stage valid bits cleared. inst_valid=0, fault=0, inst=NOP_INST. Storage contents are not cleared. ld_en is ignored while rst=1.
- Storage: DEPTH words, written on the clk edge when ld_en=1. Loader writes are independent of request traffic and stalls.
- Acceptance: a request is taken when req_valid && req_ready. req_ready = !stall, where stall = inst_valid && !inst_ready. req_ready is combinational and equals 1 during reset.
- Address decode: word index = pc[DEPTH_LOG2+1:2].
  - Fault when pc[1:0]!=0 or pc[31:DEPTH_LOG2+2]!=0.
  - Fault responses carry inst=NOP_INST, fault=1. They are ordered like any other response.
- Pipeline: LATENCY stages, each holding {valid, fault, data}.
  - Stage 1 captures the array read at the acceptance edge.
  - Stages advance together when !stall and freeze entirely when stall=1.
  - The last stage drives inst, inst_valid and fault directly from registers.
  - Un-stalled latency: request accepted at edge T gives inst_valid=1 after edge T+LATENCY-1. With LATENCY=1 the data is visible in the cycle after acceptance.
- Throughput: one request per cycle when inst_ready is held at 1. Responses are strictly in order.
- Hold rule: while inst_valid && !inst_ready, inst and fault remain stable and no new request is accepted.
- A bubble (no request accepted) produces a valid=0 stage that shifts through. inst retains its last value when inst_valid=0.
- Read/write collision: a load to the index read in the same cycle returns the old word (read-before-write). The new word appears on the next read.
- Reset mid-flight: all outstanding responses are discarded. No response for a pre-reset request ever emerges.

Decomposition:
- Shared package riscv_pkg: XLEN=32 and the NOP_INST constant. Also place there the opcode constants that core_single decode uses, so benches build words from named fields.
- Sub-module inst_mem_array: the storage, with one synchronous write port (ld_*) and one read port (read-before-write).
- The pipeline, flow control and fault logic stay in inst_mem_resp.

Test Plan:
1. Reset, then load word 0 = 32'h00A9_8933 (add x18,x19,x10) and word 1 = 32'h0000_0013. Request pc=0 with inst_ready=1 -> next cycle inst_valid=1, inst=32'h00A98933, fault=0.
2. Back-to-back requests pc=0,4,8 with inst_ready=1, LATENCY=3 -> responses on three consecutive cycles, starting 3 cycles after the first accept, in order, fault=0.
3. Misaligned pc=2, then out-of-range pc=32'h0000_0400 (DEPTH_LOG2=8) -> both respond with inst=32'h00000013, fault=1.
4. Backpressure: inst_ready=0 while a response is valid -> req_ready=0, inst stable for 5 cycles. Raise inst_ready -> the held word is consumed and the next request is accepted that same cycle.
5. Collision: word 5 holds 32'hDEAD_BEEF; request pc=20 in the same cycle as ld_en to index 5 with 32'h1234_5678 -> response 32'hDEADBEEF. Re-request pc=20 -> 32'h12345678.
6. Assert rst with 2 requests outstanding (LATENCY=3) -> inst_valid drops immediately, no stale response appears after release, and storage still holds the loaded words.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for core_single and its instruction-side helpers.
// Holds the machine width, the canonical NOP word, the base opcodes that the
// core decoder switches on, and small encoders so that benches and boot logic
// build instruction words from named fields instead of magic numbers.
// Also holds the stage record used by the instruction-memory responder.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    // Base opcodes (inst[6:0]) decoded by core_single.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // One responder pipeline stage: payload plus its qualifiers.
    typedef struct packed {
        logic            valid;
        logic            fault;
        logic [XLEN-1:0] data;
    } imem_stage_t;

    // R-type encoder: funct7 | rs2 | rs1 | funct3 | rd | opcode.
    function automatic logic [XLEN-1:0] enc_r(input logic [6:0] funct7,
                                              input logic [4:0] rs2,
                                              input logic [4:0] rs1,
                                              input logic [2:0] funct3,
                                              input logic [4:0] rd,
                                              input logic [6:0] opcode);
        return {funct7, rs2, rs1, funct3, rd, opcode};
    endfunction

    // I-type encoder: imm[11:0] | rs1 | funct3 | rd | opcode.
    function automatic logic [XLEN-1:0] enc_i(input logic [11:0] imm,
                                              input logic [4:0]  rs1,
                                              input logic [2:0]  funct3,
                                              input logic [4:0]  rd,
                                              input logic [6:0]  opcode);
        return {imm, rs1, funct3, rd, opcode};
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction word storage for inst_mem_resp.
// One synchronous write port (loader) and one combinational read port.
// Because the read is combinational and the write lands on the clock edge,
// a read and a write to the same index in one cycle returns the old word;
// the new word is visible from the next cycle on. Contents are never reset.
//
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write enable
//   wr_addr  in   write word index
//   wr_data  in   write data
//   rd_addr  in   read word index
//   rd_data  out  word currently stored at rd_addr
module inst_mem_array #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder for core_single.
// Takes fetch requests (byte pc) with valid/ready, looks the word up in a
// loader-filled array, and returns it after LATENCY pipeline stages with
// valid/ready flow control. Misaligned or out-of-range pcs return NOP_INST
// with fault=1, in order with the other responses.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active-high
//   pc          in   fetch byte address
//   req_valid   in   fetch request present
//   req_ready   out  request can be accepted this cycle
//   inst        out  returned instruction word
//   inst_valid  out  inst/fault are valid
//   inst_ready  in   core consumes the response
//   fault       out  response is for a misaligned / out-of-range pc
//   ld_en       in   loader write enable (ignored during reset)
//   ld_addr     in   loader word index
//   ld_data     in   loader write data
module inst_mem_resp
    import riscv_pkg::*;
#(
    parameter int              DEPTH_LOG2 = 8,
    parameter int              LATENCY    = 1,   // 1..4
    parameter logic [XLEN-1:0] NOP_INST   = riscv_pkg::NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       pc,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [XLEN-1:0]       inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  fault,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [XLEN-1:0]       ld_data
);

    localparam imem_stage_t RST_STAGE = '{valid: 1'b0, fault: 1'b0, data: NOP_INST};

    imem_stage_t [LATENCY:1] stg_q, stg_d;

    logic                  stall;
    logic                  accept;
    logic                  pc_fault;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [XLEN-1:0]       rd_word;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    assign wr_en  = ld_en && !rst;
    assign rd_idx = pc[DEPTH_LOG2+1:2];

    inst_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (XLEN)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_addr (rd_idx),
        .rd_data (rd_word)
    );

    // ------------------------------------------------------------------
    // Flow control and address check
    // ------------------------------------------------------------------
    // The whole pipe freezes only while the head response is refused.
    // Reset clears the head valid, so req_ready reads 1 during reset.
    assign stall     = stg_q[LATENCY].valid && !inst_ready;
    assign req_ready = !stall;
    assign accept    = req_valid && req_ready;

    assign pc_fault  = (pc[1:0] != 2'b00) || (pc[XLEN-1:DEPTH_LOG2+2] != '0);

    // ------------------------------------------------------------------
    // Pipeline
    // ------------------------------------------------------------------
    // Valid bits always shift when not stalled; payload only moves with a
    // valid entry, so a bubble leaves the previous word in place and inst
    // keeps its last value while inst_valid is low.
    always_comb begin
        stg_d = stg_q;
        if (!stall) begin
            stg_d[1].valid = accept;
            if (accept) begin
                stg_d[1].fault = pc_fault;
                stg_d[1].data  = pc_fault ? NOP_INST : rd_word;
            end
            for (int s = 2; s <= LATENCY; s++) begin
                stg_d[s].valid = stg_q[s-1].valid;
                if (stg_q[s-1].valid) begin
                    stg_d[s].fault = stg_q[s-1].fault;
                    stg_d[s].data  = stg_q[s-1].data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_q <= {LATENCY{RST_STAGE}};
        end else begin
            stg_q <= stg_d;
        end
    end

    assign inst       = stg_q[LATENCY].data;
    assign inst_valid = stg_q[LATENCY].valid;
    assign fault      = stg_q[LATENCY].fault;

endmodule
